rx_packet_ctrl: RTL and testbench
=================================

RX_PACKET_CTRL -- requirements
Module: rx_packet_ctrl

Interface
REQ-001 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-002 SHALL have port n_rst  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port d_edge  input  1  one-cycle pulse; first line transition of a packet.
REQ-004 SHALL have port shift_strobe  input  1  one-cycle pulse; one bit shifted into the 8-bit RX shift register this edge.
REQ-005 SHALL have port eop  input  1  end-of-packet detected, sampled every cycle.
REQ-006 SHALL have port rx_byte  input  8  parallel shift-register contents; valid only while byte_done=1.
REQ-007 SHALL have port byte_done  output  1  one-cycle pulse; 8 bits shifted since the last byte boundary; drives the shift register's byte_done input.
REQ-008 SHALL have port rcving  output  1  packet reception in progress.
REQ-009 SHALL have port w_enable  output  1  one-cycle write strobe to the RX FIFO; the FIFO captures rx_byte in the same cycle.
REQ-010 SHALL have port rx_pid  output  4  last accepted PID (low nibble of the PID byte).
REQ-011 SHALL have port pkt_done  output  1  one-cycle pulse on error-free packet completion.
REQ-012 SHALL have port r_error  output  1  sticky receive-error flag.

Function
REQ-013 SHALL keep a 3-bit bit counter, incremented on each counted shift_strobe, wrapping 7->0.
REQ-014 SHALL register byte_done=1 for exactly the one cycle after the strobe that wraps the counter 7->0.
REQ-015 SHALL implement states IDLE, SYNC, PID, DATA, ERR.
REQ-016 IDLE: on d_edge, SHALL go to SYNC and clear the bit counter and byte counter; shift_strobe SHALL be ignored in IDLE.
REQ-017 SYNC: on byte_done with rx_byte==SYNC_BYTE (8'h80), SHALL go to PID and clear r_error; otherwise on byte_done SHALL go to ERR.
REQ-018 PID: on byte_done with rx_byte[3:0]==~rx_byte[7:4], SHALL load rx_pid and go to DATA; otherwise SHALL go to ERR.
REQ-019 DATA: on byte_done, SHALL assert w_enable in that same cycle and increment the 7-bit byte counter.
REQ-020 DATA: a byte_done that would be the 67th data byte (more than MAX_DATA_BYTES=66) SHALL give no w_enable and SHALL go to ERR.
REQ-021 DATA: eop with bit counter==0 SHALL go to IDLE and pulse pkt_done for one cycle; zero data bytes is legal.
REQ-022 eop with bit counter!=0 in DATA, or any eop in SYNC or PID, SHALL go to ERR.
REQ-023 Entering ERR SHALL set r_error=1; ERR SHALL ignore byte_done and leave only on eop, to IDLE.
REQ-024 r_error SHALL remain 1 through IDLE and clear only on a valid sync byte (REQ-017).
REQ-025 rcving SHALL be 1 in SYNC, PID, DATA and ERR, and 0 in IDLE.
REQ-026 eop and shift_strobe in the same cycle: eop SHALL win and the strobe SHALL not be counted.
REQ-027 d_edge outside IDLE SHALL be ignored.
REQ-028 w_enable SHALL never assert outside DATA.

Reset
REQ-029 n_rst low SHALL asynchronously force IDLE, bit and byte counters=0, and byte_done, rcving, w_enable, pkt_done, r_error=0, rx_pid=4'h0, including mid-packet.
REQ-030 After reset release, the first action SHALL require a d_edge; no residual byte_done or w_enable.

Structure
REQ-031 SHALL import the shared package usb_rx_pkg, which holds the state enum, SYNC_BYTE and MAX_DATA_BYTES.
REQ-032 The bit counter SHALL be a sub-module rx_bit_counter (inputs clk, n_rst, clear, count_enable; outputs count[2:0], rollover_pulse).

Verification
REQ-033 d_edge, 8 strobes forming 8'h80, 8 strobes forming PID 8'hC3 (DATA0), 3 data bytes, eop at bit 0 -> 3 w_enable pulses, rx_pid=4'h3, one pkt_done, r_error=0.
REQ-034 Sync byte 8'h81 -> ERR and r_error=1 after that byte_done; no w_enable; after eop, IDLE with r_error still 1; next good packet clears it.
REQ-035 PID byte 8'hC2 (nibble check fails) -> ERR, rx_pid unchanged, no w_enable.
REQ-036 eop after 4 bits of the 2nd data byte -> exactly 1 w_enable, ERR, r_error=1, no pkt_done.
REQ-037 67 data bytes -> 66 w_enable pulses, then ERR on the 67th byte_done.
REQ-038 n_rst asserted in DATA mid-byte -> all outputs 0 immediately; the next packet is received correctly from its d_edge.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// Shared definitions for the USB receive path: controller states, framing
// constants and the PID integrity check.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_PID  = 3'd2,
        ST_DATA = 3'd3,
        ST_ERR  = 3'd4
    } rx_state_e;

    localparam logic [7:0] SYNC_BYTE      = 8'h80;
    localparam int         MAX_DATA_BYTES = 66;

    // A PID byte carries its 4-bit code twice: once plain, once inverted.
    function automatic logic pid_ok(input logic [7:0] b);
        return (b[3:0] == ~b[7:4]);
    endfunction

endpackage

// File: rtl/rx_packet_ctrl_if.sv
// Signal bundle between the RX line front-end (master) and the packet
// controller (slave).
interface rx_packet_ctrl_if;

    logic       d_edge;
    logic       shift_strobe;
    logic       eop;
    logic [7:0] rx_byte;
    logic       byte_done;
    logic       rcving;
    logic       w_enable;
    logic [3:0] rx_pid;
    logic       pkt_done;
    logic       r_error;

    modport master (
        output d_edge, shift_strobe, eop, rx_byte,
        input  byte_done, rcving, w_enable, rx_pid, pkt_done, r_error
    );

    modport slave (
        input  d_edge, shift_strobe, eop, rx_byte,
        output byte_done, rcving, w_enable, rx_pid, pkt_done, r_error
    );

endinterface

// File: rtl/rx_bit_counter.sv
// 3-bit bit-within-byte counter; rollover_pulse is registered, so it appears
// in the cycle after the strobe that wraps the count from 7 to 0.
module rx_bit_counter (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       count_enable,
    output logic [2:0] count,
    output logic       rollover_pulse
);

    logic [2:0] r_count;
    logic       r_rollover;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count    <= 3'd0;
            r_rollover <= 1'b0;
        end else if (clear) begin
            r_count    <= 3'd0;
            r_rollover <= 1'b0;
        end else begin
            r_rollover <= count_enable && (r_count == 3'd7);
            if (count_enable) begin
                r_count <= r_count + 3'd1;
            end
        end
    end

    assign count          = r_count;
    assign rollover_pulse = r_rollover;

endmodule

// File: rtl/rx_packet_ctrl.sv
// USB receive packet controller: frames bytes from the shift register, checks
// SYNC and PID, strobes data bytes into the RX FIFO and flags packet errors.
module rx_packet_ctrl
    import usb_rx_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    rx_packet_ctrl_if.slave  bus
);

    rx_state_e  r_state;
    rx_state_e  w_next_state;
    logic [6:0] r_byte_cnt;
    logic [3:0] r_pid;
    logic       r_err_flag;
    logic       r_pkt_done;

    logic       w_clear;
    logic       w_count_en;
    logic       w_byte_done;
    logic [2:0] w_bit_cnt;
    logic       w_write;
    logic       w_pkt_end;
    logic       w_sync_good;
    logic       w_pid_good;
    logic       w_enter_err;

    // eop takes priority over a coincident strobe, and strobes are dropped in IDLE.
    assign w_clear    = (r_state == ST_IDLE) && bus.d_edge;
    assign w_count_en = bus.shift_strobe && !bus.eop && (r_state != ST_IDLE);

    rx_bit_counter u_bit_counter (
        .clk            (clk),
        .n_rst          (n_rst),
        .clear          (w_clear),
        .count_enable   (w_count_en),
        .count          (w_bit_cnt),
        .rollover_pulse (w_byte_done)
    );

    assign w_write     = (r_state == ST_DATA) && w_byte_done &&
                         (r_byte_cnt < 7'(MAX_DATA_BYTES));
    assign w_sync_good = (r_state == ST_SYNC) && !bus.eop && w_byte_done &&
                         (bus.rx_byte == SYNC_BYTE);
    assign w_pid_good  = (r_state == ST_PID) && !bus.eop && w_byte_done &&
                         pid_ok(bus.rx_byte);

    always_comb begin
        w_next_state = r_state;
        w_pkt_end    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.d_edge) begin
                    w_next_state = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (bus.eop) begin
                    w_next_state = ST_ERR;
                end else if (w_byte_done) begin
                    w_next_state = w_sync_good ? ST_PID : ST_ERR;
                end
            end
            ST_PID: begin
                if (bus.eop) begin
                    w_next_state = ST_ERR;
                end else if (w_byte_done) begin
                    w_next_state = w_pid_good ? ST_DATA : ST_ERR;
                end
            end
            ST_DATA: begin
                // A clean end of packet must land exactly on a byte boundary.
                if (bus.eop) begin
                    if (w_bit_cnt == 3'd0) begin
                        w_next_state = ST_IDLE;
                        w_pkt_end    = 1'b1;
                    end else begin
                        w_next_state = ST_ERR;
                    end
                end else if (w_byte_done && !w_write) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_ERR: begin
                if (bus.eop) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_enter_err = (w_next_state == ST_ERR) && (r_state != ST_ERR);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= ST_IDLE;
            r_pkt_done <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_pkt_done <= w_pkt_end;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_byte_cnt <= 7'd0;
        end else if (w_clear) begin
            r_byte_cnt <= 7'd0;
        end else if (w_write) begin
            r_byte_cnt <= r_byte_cnt + 7'd1;
        end
    end

    // The error flag survives the return to IDLE; only a good SYNC clears it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_err_flag <= 1'b0;
        end else if (w_sync_good) begin
            r_err_flag <= 1'b0;
        end else if (w_enter_err) begin
            r_err_flag <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pid <= 4'h0;
        end else if (w_pid_good) begin
            r_pid <= bus.rx_byte[3:0];
        end
    end

    assign bus.byte_done = w_byte_done;
    assign bus.rcving    = (r_state != ST_IDLE);
    assign bus.w_enable  = w_write;
    assign bus.rx_pid    = r_pid;
    assign bus.pkt_done  = r_pkt_done;
    assign bus.r_error   = r_err_flag;

endmodule

// File: tb/tb_rx_packet_ctrl.sv
// Directed bench for rx_packet_ctrl: a table of whole packets with expected
// FIFO-write / completion counts, plus hand sequences for timing and reset.
module tb_rx_packet_ctrl;

    typedef struct {
        logic [7:0] syncByte;
        logic [7:0] pidByte;
        int         nData;
        int         partialBits;
        int         expWe;
        int         expPkt;
        logic       expErr;
        logic [3:0] expPid;
    } vec_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   weCount  = 0;
    int   pktCount = 0;
    int   bdCount  = 0;
    vec_t vecs[8];

    always #5 clk = ~clk;

    rx_packet_ctrl_if bus ();

    rx_packet_ctrl dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.w_enable)  weCount++;
        if (bus.pkt_done)  pktCount++;
        if (bus.byte_done) bdCount++;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic d, input logic s, input logic e);
        bus.d_edge       = d;
        bus.shift_strobe = s;
        bus.eop          = e;
        @(posedge clk);
        #1;
    endtask

    task automatic sendByte(input logic [7:0] b);
        bus.rx_byte = b;
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        step(1'b1, 1'b0, 1'b0);
        sendByte(v.syncByte);
        sendByte(v.pidByte);
        for (int i = 0; i < v.nData; i++) begin
            sendByte(8'(i + 16));
        end
        bus.rx_byte = 8'hFF;
        for (int i = 0; i < v.partialBits; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b0, 1'b0, 1'b0);
        end
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic runVec(input string name, input vec_t v);
        int we0;
        int pk0;
        we0 = weCount;
        pk0 = pktCount;
        applyStimulus(v);
        checkOutput({name, " w_enable count"}, weCount - we0, v.expWe);
        checkOutput({name, " pkt_done count"}, pktCount - pk0, v.expPkt);
        checkOutput({name, " r_error"}, bus.r_error, v.expErr);
        checkOutput({name, " rx_pid"}, bus.rx_pid, v.expPid);
        checkOutput({name, " rcving idle"}, bus.rcving, 0);
    endtask

    initial begin
        int bd0;
        int we0;
        int pk0;

        vecs[0] = '{8'h80, 8'hC3, 3,  0, 3,  1, 1'b0, 4'h3};
        vecs[1] = '{8'h81, 8'hC3, 3,  0, 0,  0, 1'b1, 4'h3};
        vecs[2] = '{8'h80, 8'hC3, 3,  0, 3,  1, 1'b0, 4'h3};
        vecs[3] = '{8'h80, 8'hC2, 2,  0, 0,  0, 1'b1, 4'h3};
        vecs[4] = '{8'h80, 8'h5A, 1,  4, 1,  0, 1'b1, 4'hA};
        vecs[5] = '{8'h80, 8'hE1, 0,  0, 0,  1, 1'b0, 4'h1};
        vecs[6] = '{8'h80, 8'h69, 66, 0, 66, 1, 1'b0, 4'h9};
        vecs[7] = '{8'h80, 8'h4B, 67, 0, 66, 0, 1'b1, 4'hB};

        bus.d_edge       = 1'b0;
        bus.shift_strobe = 1'b0;
        bus.eop          = 1'b0;
        bus.rx_byte      = 8'h00;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset outputs",
                    {bus.byte_done, bus.rcving, bus.w_enable, bus.pkt_done, bus.r_error, bus.rx_pid}, 0);
        n_rst = 1'b1;

        bd0 = bdCount;
        bus.rx_byte = 8'h80;
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checkOutput("idle strobes byte_done", bdCount - bd0, 0);
        checkOutput("idle strobes rcving", bus.rcving, 0);

        // Bad sync byte with back-to-back strobes: byte_done timing and ERR entry.
        we0 = weCount;
        step(1'b1, 1'b0, 1'b0);
        checkOutput("sync rcving", bus.rcving, 1);
        bus.rx_byte = 8'h81;
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0);
        checkOutput("byte_done before 8th", bus.byte_done, 0);
        step(1'b0, 1'b1, 1'b0);
        checkOutput("byte_done after 8th", bus.byte_done, 1);
        step(1'b0, 1'b0, 1'b0);
        checkOutput("byte_done one cycle", bus.byte_done, 0);
        checkOutput("bad sync r_error", bus.r_error, 1);
        sendByte(8'h80);
        checkOutput("err ignores byte", bus.rcving, 1);
        checkOutput("err keeps r_error", bus.r_error, 1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        checkOutput("err eop to idle", bus.rcving, 0);
        checkOutput("idle keeps r_error", bus.r_error, 1);
        checkOutput("bad sync no write", weCount - we0, 0);

        for (int i = 0; i < 8; i++) begin
            runVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Reset asserted mid-byte in DATA, then a fresh packet.
        step(1'b1, 1'b0, 1'b0);
        sendByte(8'h80);
        sendByte(8'hC3);
        sendByte(8'h55);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        checkOutput("pre-reset rcving", bus.rcving, 1);
        #2;
        n_rst = 1'b0;
        #1;
        checkOutput("async reset outputs",
                    {bus.byte_done, bus.rcving, bus.w_enable, bus.pkt_done, bus.r_error, bus.rx_pid}, 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        bd0 = bdCount;
        we0 = weCount;
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        checkOutput("post-reset byte_done", bdCount - bd0, 0);
        checkOutput("post-reset w_enable", weCount - we0, 0);
        runVec("after reset", '{8'h80, 8'hC3, 2, 0, 2, 1, 1'b0, 4'h3});

        // eop coinciding with a strobe on a byte boundary ends the packet cleanly.
        we0 = weCount;
        pk0 = pktCount;
        step(1'b1, 1'b0, 1'b0);
        sendByte(8'h80);
        sendByte(8'hA5);
        sendByte(8'h11);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        checkOutput("eop+strobe w_enable", weCount - we0, 1);
        checkOutput("eop+strobe pkt_done", pktCount - pk0, 1);
        checkOutput("eop+strobe r_error", bus.r_error, 0);
        checkOutput("eop+strobe rx_pid", bus.rx_pid, 4'h5);
        checkOutput("eop+strobe rcving", bus.rcving, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
